// File: rtl/instruction_sequencer_if.sv
// Bus bundle for instruction_sequencer: program load, run control, issue bus.
// slave = sequencer side, master = controller/consumer side.
interface instruction_sequencer_if #(
    parameter int INSTR_WIDTH = 26,
    parameter int ADDR_WIDTH  = 4
);
    logic                   load_en;
    logic [ADDR_WIDTH-1:0]  load_addr;
    logic [INSTR_WIDTH-1:0] load_data;
    logic [ADDR_WIDTH-1:0]  last_addr;
    logic                   loop_en;
    logic                   start;
    logic                   stop;
    logic                   stall;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   busy;
    logic                   done;

    modport slave (
        input  load_en, load_addr, load_data, last_addr,
        input  loop_en, start, stop, stall,
        output instruction, instr_valid, pc, busy, done
    );

    modport master (
        output load_en, load_addr, load_data, last_addr,
        output loop_en, start, stop, stall,
        input  instruction, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Loadable 16-entry program store issuing one instruction per clock to the ALU.
// Ports: clock, reset_n (async low), bus (slave): load/control in, instruction/pc/status out.
module instruction_sequencer #(
    parameter int INSTR_WIDTH = 26,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    instruction_sequencer_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, done_q;
    logic [ADDR_WIDTH-1:0]  pc_inc;
    logic                   wr_en;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    assign pc_inc = pc_q + 1'b1;
    assign wr_en  = bus.load_en && (state_q != RUN);

    // Nonblocking write: a read in the same cycle sees the old word.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE, DONE: begin
                // A pending load takes the cycle; start is dropped.
                if (bus.load_en) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    state_d = RUN;
                    instr_d = mem[ADDR_ZERO];
                    pc_d    = ADDR_ZERO;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (bus.stall) begin
                    state_d = RUN;
                end else if (pc_q != bus.last_addr) begin
                    pc_d    = pc_inc;
                    instr_d = mem[pc_inc];
                end else if (bus.loop_en) begin
                    pc_d    = ADDR_ZERO;
                    instr_d = mem[ADDR_ZERO];
                end else begin
                    state_d = DONE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer.
// Issued words are matched against a queue of expected (instruction, pc) pairs.
module tb_instruction_sequencer;
    localparam int IW = 26;
    localparam int AW = 4;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic [IW-1:0] prog [8];

    instruction_sequencer_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

    instruction_sequencer #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every live word must be the next expected one.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && bus.instr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 32'(bus.pc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_instr", 32'(bus.instruction), 32'(e.instr));
                check("sb_pc", 32'(bus.pc), 32'(e.pc));
            end
        end
    end

    task automatic push(input int idx, input int n);
        exp_t e;
        e.instr = prog[idx];
        e.pc    = AW'(idx);
        for (int i = 0; i < n; i++)
            sb.push_back(e);
    endtask

    task automatic push_run(input int last);
        for (int i = 0; i <= last; i++)
            push(i, 1);
    endtask

    task automatic load(input int addr, input logic [IW-1:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = AW'(addr);
        bus.load_data = data;
        @(negedge clock);
        bus.load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        if (cnt >= 100)
            check("timeout_done", 32'(cnt), 32'd0);
    endtask

    task automatic wait_pc(input int p);
        int cnt;
        cnt = 0;
        while (!(bus.instr_valid === 1'b1 && bus.pc === AW'(p)) && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        if (cnt >= 100)
            check("timeout_pc", 32'(cnt), 32'd0);
    endtask

    initial begin
        int cnt;
        prog[0] = 26'h04E1200;
        prog[1] = 26'h14E1200;
        prog[2] = 26'h34E1200;
        prog[3] = 26'h24E1200;
        prog[4] = 26'h0787C00;
        prog[5] = 26'h0ABCDEF;
        prog[6] = 26'h1234567;
        prog[7] = '0;

        bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
        bus.last_addr = '0; bus.loop_en = 0; bus.start = 0;
        bus.stop = 0; bus.stall = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_instr", 32'(bus.instruction), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);

        for (int i = 0; i < 5; i++)
            load(i, prog[i]);

        // Run once
        bus.last_addr = 4'd4;
        bus.loop_en   = 1'b0;
        push_run(4);
        pulse_start();
        check("run_busy", 32'(bus.busy), 32'd1);
        wait_done(cnt);
        check("run_len", 32'(cnt), 32'd5);
        check("run_done_valid", 32'(bus.instr_valid), 32'd0);
        check("run_done_instr", 32'(bus.instruction), 32'(prog[4]));
        check("run_done_pc", 32'(bus.pc), 32'd4);
        check("run_done_busy", 32'(bus.busy), 32'd0);
        check("run_sb_empty", 32'(sb.size()), 32'd0);

        // Stall for 3 cycles at pc 2
        push(0, 1); push(1, 1); push(2, 4); push(3, 1); push(4, 1);
        pulse_start();
        wait_pc(2);
        bus.stall = 1'b1;
        repeat (3) @(negedge clock);
        check("stall_pc", 32'(bus.pc), 32'd2);
        check("stall_instr", 32'(bus.instruction), 32'(prog[2]));
        bus.stall = 1'b0;
        wait_done(cnt);
        check("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Load attempted during a run is ignored
        push_run(4);
        pulse_start();
        bus.load_en   = 1'b1;
        bus.load_addr = 4'd3;
        bus.load_data = 26'h3FFFFFF;
        repeat (2) @(negedge clock);
        bus.load_en   = 1'b0;
        wait_done(cnt);
        push_run(4);
        pulse_start();
        wait_done(cnt);
        check("blk_sb_empty", 32'(sb.size()), 32'd0);

        // Load in DONE returns to IDLE; load+start in IDLE only writes
        load(5, prog[5]);
        check("dload_done", 32'(bus.done), 32'd0);
        check("dload_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        load(6, prog[6]);
        bus.start = 1'b0;
        check("ls_busy", 32'(bus.busy), 32'd0);
        check("ls_valid", 32'(bus.instr_valid), 32'd0);
        @(negedge clock);
        check("ls_busy2", 32'(bus.busy), 32'd0);
        bus.last_addr = 4'd6;
        push_run(6);
        pulse_start();
        wait_done(cnt);
        check("ls_len", 32'(cnt), 32'd7);
        check("ls_sb_empty", 32'(sb.size()), 32'd0);

        // Loop with no gap, then stop beats stall
        bus.last_addr = 4'd1;
        bus.loop_en   = 1'b1;
        for (int i = 0; i < 3; i++) push_run(1);
        pulse_start();
        repeat (5) @(negedge clock);
        bus.stop  = 1'b1;
        bus.stall = 1'b1;
        @(negedge clock);
        bus.stop  = 1'b0;
        bus.stall = 1'b0;
        check("stop_valid", 32'(bus.instr_valid), 32'd0);
        check("stop_busy", 32'(bus.busy), 32'd0);
        check("stop_done", 32'(bus.done), 32'd0);
        check("stop_instr", 32'(bus.instruction), 32'(prog[1]));
        check("stop_pc", 32'(bus.pc), 32'd1);
        check("loop_sb_empty", 32'(sb.size()), 32'd0);

        // Async reset mid-run
        bus.last_addr = 4'd4;
        bus.loop_en   = 1'b0;
        push_run(2);
        pulse_start();
        wait_pc(2);
        #2 reset_n = 1'b0;
        #1;
        check("arst_instr", 32'(bus.instruction), 32'd0);
        check("arst_valid", 32'(bus.instr_valid), 32'd0);
        check("arst_pc", 32'(bus.pc), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // One-instruction program after reset: memory retained
        bus.last_addr = 4'd0;
        push_run(0);
        pulse_start();
        wait_done(cnt);
        check("one_len", 32'(cnt), 32'd1);
        check("one_instr", 32'(bus.instruction), 32'(prog[0]));
        check("one_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
